multiport_ram_2w2r: RTL and testbench
=====================================

Name: multiport_ram_2w2r

Overview:
- Synchronous RAM with two independent write ports and two independent read ports, all in one clock domain.
- Used as a shared register/data store when two agents must each write and read in the same cycle.
- Internally built as a live-value-table (LVT) multiport RAM:
  - one bank per write port, each bank replicated per read port (4 simple dual-port arrays);
  - plus an RAM_DEPTH x 1-bit LVT recording which write port last wrote each address.

Parameters:
- ADDR_WIDTH, 8, address width of every port.
- RAM_DEPTH, 2**ADDR_WIDTH (256), number of words; must equal 2**ADDR_WIDTH.
- DATA_WIDTH, 32, word width.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- wren1  in  1  write enable, port 1.
- wraddr1  in  ADDR_WIDTH  write address, port 1.
- wrdata1  in  DATA_WIDTH  write data, port 1.
- wren2  in  1  write enable, port 2.
- wraddr2  in  ADDR_WIDTH  write address, port 2.
- wrdata2  in  DATA_WIDTH  write data, port 2.
- rden1  in  1  read enable, port 1.
- rdaddr1  in  ADDR_WIDTH  read address, port 1.
- rddata1  out  DATA_WIDTH  read data, port 1.
- rden2  in  1  read enable, port 2.
- rdaddr2  in  ADDR_WIDTH  read address, port 2.
- rddata2  out  DATA_WIDTH  read data, port 2.

Behaviour:
- Reset (aresetn low, asynchronous):
  - rddata1 and rddata2 go to 0;
  - LVT entries go to 0 (point at bank 1);
  - array contents are not cleared, so data at any address is undefined after reset until rewritten;
  - writes and reads are ignored while reset is asserted.
- Write:
  - at a rising edge with wrenN=1, wrdataN is stored at wraddrN in bank N (all read copies);
  - the LVT entry at wraddrN is set to N-1.
- Simultaneous writes to different addresses: both commit in the same cycle.
- Simultaneous writes to the same address: port 2 wins; a subsequent read returns wrdata2.
- Read:
  - at a rising edge with rdenN=1, rdaddrN is sampled;
  - rddataN is registered and valid after that edge (1-cycle latency);
  - data comes from the bank selected by the LVT entry at rdaddrN.
- When rdenN=0, rddataN holds its last value.
- Both read ports are fully independent and may read the same or different addresses in the same cycle.
- Read-during-write to the same address in the same cycle returns the old (pre-write) word (read-first), unless the optional feature is enabled.
- Addresses are used modulo 2**ADDR_WIDTH; there is no out-of-range case.
- Reset asserted mid-operation: any in-flight read result is discarded (rddata forced to 0); a write coinciding with reset is not committed.
- No handshake or back-pressure: every enabled access completes in one cycle.

Optional Feature:
- Macro: MEDURAM_WR_BYPASS_EN.
- When defined: a read that samples the same address as a same-cycle write returns the new data (write-first). If both write ports hit that address, wrdata2 is returned. The LVT is also bypassed for that cycle.
- When undefined: read-first behaviour as above.

Test Plan:
- Basic round trip:
  - reset, then write port 2 addr 100 data 0x0000BEEF for one cycle;
  - read port 2 addr 100;
  - rddata2 = 0x0000BEEF one cycle after rden2 sampled.
- Cross-port visibility:
  - write port 1 addr 5 = 0xDEADBEEF and port 2 addr 6 = 0x12345678 in the same cycle;
  - read port 1 addr 6 and port 2 addr 5 in the next cycle;
  - rddata1 = 0x12345678, rddata2 = 0xDEADBEEF.
- Write collision: both ports write addr 0x20 (port 1 0x1111, port 2 0x2222) in the same cycle -> a later read of 0x20 on either port returns 0x2222.
- Overwrite across banks: port 2 writes addr 7 = 0xA, then port 1 writes addr 7 = 0xB -> reads on both ports return 0xB.
- Read-during-write on addr 9 (old value 0x1, new value 0x2):
  - rddata = 0x1 without MEDURAM_WR_BYPASS_EN;
  - rddata = 0x2 with it.
- Reset and hold:
  - read returns 0x55, then rden low for 3 cycles -> rddata stays 0x55;
  - assert aresetn=0 between edges -> rddata1 and rddata2 go to 0 immediately.

Source files
------------

// File: rtl/multiport_ram_2w2r.sv
// Two-write / two-read synchronous RAM built as a live-value-table multiport memory.
// Optional write-first bypass on reads: define MEDURAM_WR_BYPASS_EN.

module multiport_ram_2w2r_bank #(
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 2**ADDR_WIDTH,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    always_ff @(posedge aclk) begin
        if (wen)
            mem[waddr] <= wdata;
    end

    // Asynchronous read; the registered output lives in the top after the LVT mux.
    assign rdata = mem[raddr];
endmodule

module multiport_ram_2w2r #(
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 2**ADDR_WIDTH,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  wren1,
    input  logic [ADDR_WIDTH-1:0] wraddr1,
    input  logic [DATA_WIDTH-1:0] wrdata1,
    input  logic                  wren2,
    input  logic [ADDR_WIDTH-1:0] wraddr2,
    input  logic [DATA_WIDTH-1:0] wrdata2,
    input  logic                  rden1,
    input  logic [ADDR_WIDTH-1:0] rdaddr1,
    output logic [DATA_WIDTH-1:0] rddata1,
    input  logic                  rden2,
    input  logic [ADDR_WIDTH-1:0] rdaddr2,
    output logic [DATA_WIDTH-1:0] rddata2
);
    localparam int NUM_WR = 2;
    localparam int NUM_RD = 2;

    logic [NUM_WR-1:0]                                wen;
    logic [NUM_WR-1:0][ADDR_WIDTH-1:0]                waddr;
    logic [NUM_WR-1:0][DATA_WIDTH-1:0]                wdata;
    logic [NUM_RD-1:0]                                ren;
    logic [NUM_RD-1:0][ADDR_WIDTH-1:0]                raddr;
    logic [NUM_WR-1:0][NUM_RD-1:0][DATA_WIDTH-1:0]    bank_rd;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0]                word;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0]                rd_q;
    logic [RAM_DEPTH-1:0]                             lvt;

    // Writes arriving while reset is held are dropped.
    assign wen   = {wren2, wren1} & {NUM_WR{aresetn}};
    assign waddr = {wraddr2, wraddr1};
    assign wdata = {wrdata2, wrdata1};
    assign ren   = {rden2, rden1};
    assign raddr = {rdaddr2, rdaddr1};

    genvar w, r;
    generate
        for (w = 0; w < NUM_WR; w++) begin : g_wr
            for (r = 0; r < NUM_RD; r++) begin : g_rd
                multiport_ram_2w2r_bank #(
                    .ADDR_WIDTH (ADDR_WIDTH),
                    .RAM_DEPTH  (RAM_DEPTH),
                    .DATA_WIDTH (DATA_WIDTH)
                ) u_bank (
                    .aclk  (aclk),
                    .wen   (wen[w]),
                    .waddr (waddr[w]),
                    .wdata (wdata[w]),
                    .raddr (raddr[r]),
                    .rdata (bank_rd[w][r])
                );
            end
        end
    endgenerate

    // LVT: 1 means write port 2 holds the live copy. Port 2 is assigned last so it wins collisions.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lvt <= '0;
        end else begin
            if (wen[0]) lvt[waddr[0]] <= 1'b0;
            if (wen[1]) lvt[waddr[1]] <= 1'b1;
        end
    end

    generate
        for (r = 0; r < NUM_RD; r++) begin : g_sel
`ifdef MEDURAM_WR_BYPASS_EN
            assign word[r] = (wen[1] && waddr[1] == raddr[r]) ? wdata[1] :
                             (wen[0] && waddr[0] == raddr[r]) ? wdata[0] :
                             (lvt[raddr[r]] ? bank_rd[1][r] : bank_rd[0][r]);
`else
            assign word[r] = lvt[raddr[r]] ? bank_rd[1][r] : bank_rd[0][r];
`endif
        end
    endgenerate

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_q <= '0;
        end else begin
            for (int i = 0; i < NUM_RD; i++)
                if (ren[i]) rd_q[i] <= word[i];
        end
    end

    assign rddata1 = rd_q[0];
    assign rddata2 = rd_q[1];
endmodule

// File: tb/tb_multiport_ram_2w2r.sv
// Bench for multiport_ram_2w2r: directed vector table, reset sequence, then random traffic vs. a memory model.
module tb_multiport_ram_2w2r;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic        wren1, wren2, rden1, rden2;
    logic [7:0]  wraddr1, wraddr2, rdaddr1, rdaddr2;
    logic [31:0] wrdata1, wrdata2, rddata1, rddata2;

    int errors = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    multiport_ram_2w2r dut (
        .aclk(aclk), .aresetn(aresetn),
        .wren1(wren1), .wraddr1(wraddr1), .wrdata1(wrdata1),
        .wren2(wren2), .wraddr2(wraddr2), .wrdata2(wrdata2),
        .rden1(rden1), .rdaddr1(rdaddr1), .rddata1(rddata1),
        .rden2(rden2), .rdaddr2(rdaddr2), .rddata2(rddata2)
    );

    typedef struct {
        logic        w1; logic [7:0] a1; logic [31:0] d1;
        logic        w2; logic [7:0] a2; logic [31:0] d2;
        logic        r1; logic [7:0] ra1;
        logic        r2; logic [7:0] ra2;
        logic        c1; logic [31:0] e1;
        logic        c2; logic [31:0] e2;
    } vec_t;

`ifdef MEDURAM_WR_BYPASS_EN
    localparam logic [31:0] RDW = 32'h2;
`else
    localparam logic [31:0] RDW = 32'h1;
`endif

    vec_t tbl[$];

    function automatic vec_t mk(input logic w1, input logic [7:0] a1, input logic [31:0] d1,
                                input logic w2, input logic [7:0] a2, input logic [31:0] d2,
                                input logic r1, input logic [7:0] ra1,
                                input logic r2, input logic [7:0] ra2,
                                input logic c1, input logic [31:0] e1,
                                input logic c2, input logic [31:0] e2);
        vec_t v;
        v.w1 = w1; v.a1 = a1; v.d1 = d1; v.w2 = w2; v.a2 = a2; v.d2 = d2;
        v.r1 = r1; v.ra1 = ra1; v.r2 = r2; v.ra2 = ra2;
        v.c1 = c1; v.e1 = e1; v.c2 = c2; v.e2 = e2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        wren1 = v.w1; wraddr1 = v.a1; wrdata1 = v.d1;
        wren2 = v.w2; wraddr2 = v.a2; wrdata2 = v.d2;
        rden1 = v.r1; rdaddr1 = v.ra1;
        rden2 = v.r2; rdaddr2 = v.ra2;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    // Reference model: plain word array with a "known" flag per address.
    logic [31:0] m_mem [256];
    bit          m_ok  [256];
    logic [31:0] exp_q [2];
    bit          exp_ok[2];

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_ok[i] = 1'b0;
        for (int p = 0; p < 2; p++) begin exp_q[p] = '0; exp_ok[p] = 1'b1; end
    endtask

    task automatic model_step(input vec_t v);
        logic       rd [2];
        logic [7:0] ra [2];
        rd[0] = v.r1; ra[0] = v.ra1; rd[1] = v.r2; ra[1] = v.ra2;
        for (int p = 0; p < 2; p++) begin
            if (rd[p]) begin
                exp_q[p]  = m_mem[ra[p]];
                exp_ok[p] = m_ok[ra[p]];
`ifdef MEDURAM_WR_BYPASS_EN
                if (v.w2 && v.a2 == ra[p]) begin exp_q[p] = v.d2; exp_ok[p] = 1'b1; end
                else if (v.w1 && v.a1 == ra[p]) begin exp_q[p] = v.d1; exp_ok[p] = 1'b1; end
`endif
            end
        end
        if (v.w1) begin m_mem[v.a1] = v.d1; m_ok[v.a1] = 1'b1; end
        if (v.w2) begin m_mem[v.a2] = v.d2; m_ok[v.a2] = 1'b1; end
    endtask

    initial begin
        aresetn = 1'b0;
        idle();
        repeat (2) @(posedge aclk);
        #1;
        check("reset_rd1", rddata1, 32'h0);
        check("reset_rd2", rddata2, 32'h0);
        @(negedge aclk);
        aresetn = 1'b1;

        //            w1 a1     d1            w2 a2     d2            r1 ra1    r2 ra2    c1 e1            c2 e2
        tbl.push_back(mk(0, 8'd0,  32'h0,        1, 8'd100, 32'h0000BEEF, 0, 8'd0,  0, 8'd0,  1, 32'h0,        1, 32'h0));
        tbl.push_back(mk(0, 8'd0,  32'h0,        0, 8'd0,   32'h0,        0, 8'd0,  1, 8'd100, 1, 32'h0,       1, 32'h0000BEEF));
        tbl.push_back(mk(1, 8'd5,  32'hDEADBEEF, 1, 8'd6,   32'h12345678, 0, 8'd0,  0, 8'd0,  0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 8'd0,  32'h0,        0, 8'd0,   32'h0,        1, 8'd6,  1, 8'd5,  1, 32'h12345678, 1, 32'hDEADBEEF));
        tbl.push_back(mk(1, 8'h20, 32'h1111,     1, 8'h20,  32'h2222,     0, 8'd0,  0, 8'd0,  0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 8'd0,  32'h0,        0, 8'd0,   32'h0,        1, 8'h20, 1, 8'h20, 1, 32'h2222,     1, 32'h2222));
        tbl.push_back(mk(0, 8'd0,  32'h0,        1, 8'd7,   32'hA,        0, 8'd0,  0, 8'd0,  0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(1, 8'd7,  32'hB,        0, 8'd0,   32'h0,        0, 8'd0,  0, 8'd0,  0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 8'd0,  32'h0,        0, 8'd0,   32'h0,        1, 8'd7,  1, 8'd7,  1, 32'hB,        1, 32'hB));
        tbl.push_back(mk(1, 8'd9,  32'h1,        0, 8'd0,   32'h0,        0, 8'd0,  0, 8'd0,  0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(1, 8'd9,  32'h2,        0, 8'd0,   32'h0,        1, 8'd9,  1, 8'd9,  1, RDW,          1, RDW));
        tbl.push_back(mk(0, 8'd0,  32'h0,        0, 8'd0,   32'h0,        1, 8'd9,  0, 8'd0,  1, 32'h2,        1, RDW));
        tbl.push_back(mk(1, 8'h33, 32'h55,       1, 8'h34,  32'h55,       0, 8'd0,  0, 8'd0,  0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 8'd0,  32'h0,        0, 8'd0,   32'h0,        1, 8'h33, 1, 8'h34, 1, 32'h55,       1, 32'h55));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 8'd0, 32'h0,     1, 8'h33,  32'h99,       0, 8'h33, 0, 8'h34, 1, 32'h55,       1, 32'h55));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge aclk);
            drive(tbl[i]);
            @(posedge aclk);
            #1;
            if (tbl[i].c1) check($sformatf("vec%0d_rd1", i), rddata1, tbl[i].e1);
            if (tbl[i].c2) check($sformatf("vec%0d_rd2", i), rddata2, tbl[i].e2);
        end

        // Reset between edges clears outputs at once; reads and writes stay ignored while held.
        @(negedge aclk);
        idle();
        #2 aresetn = 1'b0;
        #1;
        check("async_rst_rd1", rddata1, 32'h0);
        check("async_rst_rd2", rddata2, 32'h0);
        drive(mk(1, 8'h33, 32'h77, 1, 8'h34, 32'h77, 1, 8'h33, 1, 8'h34, 0, 0, 0, 0));
        @(posedge aclk);
        #1;
        check("rst_hold_rd1", rddata1, 32'h0);
        check("rst_hold_rd2", rddata2, 32'h0);
        @(negedge aclk);
        idle();
        aresetn = 1'b1;

        // Random traffic on a narrow address window to provoke collisions and read-during-write.
        model_reset();
        for (int c = 0; c < 600; c++) begin
            vec_t v;
            v = mk($urandom_range(0, 1), 8'($urandom_range(0, 15)), $urandom,
                   $urandom_range(0, 1), 8'($urandom_range(0, 15)), $urandom,
                   $urandom_range(0, 2) != 0, 8'($urandom_range(0, 15)),
                   $urandom_range(0, 2) != 0, 8'($urandom_range(0, 15)), 0, 0, 0, 0);
            @(negedge aclk);
            drive(v);
            model_step(v);
            @(posedge aclk);
            #1;
            if (exp_ok[0]) check($sformatf("rand%0d_rd1", c), rddata1, exp_q[0]);
            if (exp_ok[1]) check($sformatf("rand%0d_rd2", c), rddata2, exp_q[1]);
        end

        @(negedge aclk);
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
